// File: rtl/rgb2gray_deadlock_detector.sv
// Deadlock detector for the rgb2gray kernel monitor: declares a stall once the
// block/idle pattern has stayed unchanged for THRESHOLD consecutive cycles.
module rgb2gray_deadlock_detector #(
    parameter int N_AXIS    = 2,
    parameter int N_INST    = 2,
    parameter int N_IBLK    = 1,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 8,
    parameter int STICKY    = 0
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_IBLK-1:0] inst_block_sigs,
    output logic              block,
    output logic              block_pulse,
    output logic [N_AXIS-1:0] block_axis_snap,
    output logic [CNT_W-1:0]  stall_count,
    output logic [7:0]        block_events
);

    localparam int              PAT_W   = N_AXIS + N_IBLK;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit              THR_ONE = (THRESHOLD == 1);
    localparam bit              IS_STICKY = (STICKY != 0);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        BLOCKED
    } state_e;

    state_e              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                block_q, block_d;
    logic                pulse_q, pulse_d;
    logic [N_AXIS-1:0]   snap_q, snap_d;
    logic [7:0]          ev_q, ev_d;

    logic                stall;
    logic [PAT_W-1:0]    pat;
    logic [CNT_W-1:0]    cnt_inc;
    logic                entry;

    // A fully idle kernel is never treated as deadlocked.
    assign stall   = enable & ~(&inst_idle_sigs) & ((|axis_block_sigs) | (|inst_block_sigs));
    assign pat     = {inst_block_sigs, axis_block_sigs};
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        block_d = block_q;
        pulse_d = 1'b0;
        snap_d  = snap_q;
        ev_d    = ev_q;
        entry   = 1'b0;

        if (clear) begin
            if (IS_STICKY) begin
                block_d = 1'b0;
            end
            snap_d = '0;
            ev_d   = 8'd0;
        end

        case (state_q)
            IDLE: begin
                if (stall) begin
                    pat_d = pat;
                    cnt_d = CNT_ONE;
                    if (THR_ONE) begin
                        state_d = BLOCKED;
                        entry   = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            COUNT: begin
                if (!stall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pat != pat_q) begin
                    pat_d = pat;
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == THR) begin
                        state_d = BLOCKED;
                        entry   = 1'b1;
                    end
                end
            end
            BLOCKED: begin
                // Any progress (stall gone or pattern moved) ends the episode.
                if (!stall || (pat != pat_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!IS_STICKY) begin
                        block_d = 1'b0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Entry overrides a simultaneous clear.
        if (entry) begin
            block_d = 1'b1;
            pulse_d = 1'b1;
            snap_d  = axis_block_sigs;
            if (clear) begin
                ev_d = 8'd1;
            end else if (ev_q != 8'hFF) begin
                ev_d = ev_q + 8'd1;
            end else begin
                ev_d = ev_q;
            end
        end
    end

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            block_q <= 1'b0;
            pulse_q <= 1'b0;
            snap_q  <= '0;
            ev_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
            pulse_q <= pulse_d;
            snap_q  <= snap_d;
            ev_q    <= ev_d;
        end
    end

    assign block           = block_q;
    assign block_pulse     = pulse_q;
    assign block_axis_snap = snap_q;
    assign stall_count     = cnt_q;
    assign block_events    = ev_q;

endmodule

// File: tb/tb_rgb2gray_deadlock_detector.sv
// Bench for rgb2gray_deadlock_detector: a non-sticky and a sticky instance share
// stimulus and are checked against a run-length model of the stall pattern.
module tb_rgb2gray_deadlock_detector;

    localparam int THR = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [1:0] axis;
    logic [1:0] idle;
    logic [0:0] iblk;

    logic       block0, pulse0, block1, pulse1;
    logic [1:0] snap0, snap1;
    logic [7:0] cnt0, cnt1, ev0, ev1;

    int checkCount = 0;
    int passCount  = 0;

    rgb2gray_deadlock_detector #(
        .N_AXIS(2), .N_INST(2), .N_IBLK(1), .THRESHOLD(THR), .CNT_W(8), .STICKY(0)
    ) dut0 (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .enable(enable),
        .clear(clear),
        .axis_block_sigs(axis),
        .inst_idle_sigs(idle),
        .inst_block_sigs(iblk),
        .block(block0),
        .block_pulse(pulse0),
        .block_axis_snap(snap0),
        .stall_count(cnt0),
        .block_events(ev0)
    );

    rgb2gray_deadlock_detector #(
        .N_AXIS(2), .N_INST(2), .N_IBLK(1), .THRESHOLD(THR), .CNT_W(8), .STICKY(1)
    ) dut1 (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .enable(enable),
        .clear(clear),
        .axis_block_sigs(axis),
        .inst_idle_sigs(idle),
        .inst_block_sigs(iblk),
        .block(block1),
        .block_pulse(pulse1),
        .block_axis_snap(snap1),
        .stall_count(cnt1),
        .block_events(ev1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: length of the current run of stall cycles with an unchanged pattern.
    int         run = 0;
    logic [2:0] lastPat = '0;
    logic       mStk = 1'b0;
    logic       mPulse = 1'b0;
    logic [1:0] mSnap = '0;
    int         mEv = 0;

    always @(posedge clk or negedge rst) begin
        int   newRun;
        bit   stallNow;
        bit   entry;
        if (!rst) begin
            run     <= 0;
            lastPat <= '0;
            mStk    <= 1'b0;
            mPulse  <= 1'b0;
            mSnap   <= '0;
            mEv     <= 0;
        end else begin
            stallNow = enable && (idle != 2'b11) && ((axis != 2'b00) || iblk[0]);
            if (!stallNow) begin
                newRun = 0;
            end else if (run > 0 && {iblk, axis} == lastPat) begin
                newRun = run + 1;
            end else if (run >= THR) begin
                newRun = 0;
            end else begin
                newRun = 1;
            end
            entry = (newRun == THR);
            if (stallNow) lastPat <= {iblk, axis};
            run    <= newRun;
            mPulse <= entry;
            if (entry) begin
                mSnap <= axis;
                mStk  <= 1'b1;
                mEv   <= clear ? 1 : ((mEv < 255) ? mEv + 1 : 255);
            end else if (clear) begin
                mSnap <= '0;
                mStk  <= 1'b0;
                mEv   <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int mCnt;
        if (rst === 1'b1) begin
            mCnt = (run > 255) ? 255 : run;
            checkOutput("m.block0", int'(block0), int'(run >= THR));
            checkOutput("m.block1", int'(block1), int'(mStk));
            checkOutput("m.pulse0", int'(pulse0), int'(mPulse));
            checkOutput("m.pulse1", int'(pulse1), int'(mPulse));
            checkOutput("m.snap0", int'(snap0), int'(mSnap));
            checkOutput("m.snap1", int'(snap1), int'(mSnap));
            checkOutput("m.cnt0", int'(cnt0), mCnt);
            checkOutput("m.cnt1", int'(cnt1), mCnt);
            checkOutput("m.ev0", int'(ev0), mEv);
            checkOutput("m.ev1", int'(ev1), mEv);
        end
    end

    task automatic applyStimulus(input bit en, input bit clr, input logic [1:0] ax,
                                 input logic [1:0] idl, input bit ib, input int cycles);
        enable  = en;
        clear   = clr;
        axis    = ax;
        idle    = idl;
        iblk[0] = ib;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int maxCnt;
        bit anyBlock;
        int holdLen;
        logic [1:0] rAxis, rIdle;
        bit rIb, rEn;

        rst = 1'b0;
        enable = 1'b0;
        clear = 1'b0;
        axis = '0;
        idle = '0;
        iblk = '0;

        #12;
        checkOutput("rst.block", int'(block0), 0);
        checkOutput("rst.pulse", int'(pulse0), 0);
        checkOutput("rst.snap", int'(snap0), 0);
        checkOutput("rst.cnt", int'(cnt0), 0);
        checkOutput("rst.ev", int'(ev0), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] stable stall of axis=01");
        applyStimulus(1, 0, 2'b01, 2'b00, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("t1.cnt", int'(cnt0), i);
            checkOutput("t1.block", int'(block0), int'(i >= 4));
            checkOutput("t1.pulse", int'(pulse0), int'(i == 4));
        end
        checkOutput("t1.snap", int'(snap0), 1);
        checkOutput("t1.ev", int'(ev0), 1);

        applyStimulus(1, 0, 2'b00, 2'b00, 0, 1);
        checkOutput("t2.block0", int'(block0), 0);
        checkOutput("t2.cnt0", int'(cnt0), 0);
        checkOutput("t2.block1", int'(block1), 1);

        $display("[TB] alternating pattern");
        maxCnt = 0;
        anyBlock = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, (i % 4 < 2) ? 2'b01 : 2'b10, 2'b00, 0, 1);
            if (int'(cnt0) > maxCnt) maxCnt = int'(cnt0);
            if (block0) anyBlock = 1'b1;
        end
        checkOutput("t3.maxCnt", maxCnt, 2);
        checkOutput("t3.anyBlock", int'(anyBlock), 0);

        applyStimulus(1, 0, 2'b11, 2'b11, 0, 50);
        checkOutput("t4.cnt", int'(cnt0), 0);
        checkOutput("t4.block", int'(block0), 0);

        $display("[TB] sticky clear and re-stall");
        applyStimulus(1, 1, 2'b00, 2'b00, 0, 1);
        checkOutput("t5.clr.block1", int'(block1), 0);
        checkOutput("t5.clr.snap1", int'(snap1), 0);
        checkOutput("t5.clr.ev1", int'(ev1), 0);
        applyStimulus(1, 0, 2'b10, 2'b01, 0, 4);
        checkOutput("t5.block1", int'(block1), 1);
        checkOutput("t5.ev1", int'(ev1), 1);
        checkOutput("t5.snap1", int'(snap1), 2);
        applyStimulus(1, 0, 2'b00, 2'b01, 0, 1);
        checkOutput("t5.hold.block1", int'(block1), 1);
        checkOutput("t5.drop.block0", int'(block0), 0);

        $display("[TB] reset mid-count");
        applyStimulus(1, 0, 2'b01, 2'b00, 0, 3);
        checkOutput("t6.cnt", int'(cnt0), 3);
        #3 rst = 1'b0;
        #1;
        checkOutput("t6.rst.cnt0", int'(cnt0), 0);
        checkOutput("t6.rst.block1", int'(block1), 0);
        checkOutput("t6.rst.ev1", int'(ev1), 0);
        axis = 2'b00;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 2'b01, 2'b00, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("t6.cnt", int'(cnt0), i);
            checkOutput("t6.block", int'(block0), int'(i == 4));
        end

        $display("[TB] saturation");
        applyStimulus(1, 0, 2'b00, 2'b00, 0, 1);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 0, 2'b11, 2'b00, 1, 4);
            applyStimulus(1, 0, 2'b00, 2'b00, 0, 1);
        end
        checkOutput("sat.ev", int'(ev0), 255);
        applyStimulus(1, 0, 2'b01, 2'b10, 0, 300);
        checkOutput("sat.cnt", int'(cnt0), 255);
        checkOutput("sat.block", int'(block0), 1);
        checkOutput("sat.ev2", int'(ev0), 255);

        $display("[TB] random phase");
        for (int i = 0; i < 150; i++) begin
            holdLen = $urandom_range(1, 8);
            rAxis   = 2'($urandom_range(0, 3));
            rIdle   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rIb     = ($urandom_range(0, 4) == 0);
            rEn     = ($urandom_range(0, 9) != 0);
            for (int j = 0; j < holdLen; j++) begin
                applyStimulus(rEn, ($urandom_range(0, 15) == 0), rAxis, rIdle, rIb, 1);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rgb2gray_deadlock_detector.md
Name: rgb2gray_deadlock_detector

Overview:
Sequential deadlock detector that consumes the per-kernel block/idle vectors gathered by the rgb2gray_top kernel monitor top. These are the AXIS port blocked flags (src, dst), the instance idle flags and the instance block flags. It asserts a qualified `block` when the kernel holds an unchanged stall pattern for a programmable number of consecutive cycles. It also captures which AXIS ports caused the stall, so the diagnosis report can be printed.

Parameters:
N_AXIS, 2, number of AXIS block flags (bit0 = src read blocked, bit1 = dst write blocked)
N_INST, 2, number of instance idle flags
N_IBLK, 1, number of instance block flags
THRESHOLD, 16, consecutive stable stall cycles needed to declare deadlock (legal range 1..2^CNT_W-1)
CNT_W, 8, width of the stall counter
STICKY, 0, 1 = `block` holds until `clear`; 0 = `block` drops when the stall resolves

Ports:
kernel_monitor_clock  in  1  sole clock, rising edge
kernel_monitor_reset  in  1  asynchronous, active-low reset
enable  in  1  0 = detector frozen in IDLE, counter zeroed
clear  in  1  synchronous clear of the sticky block, the snapshot and the event counter
axis_block_sigs  in  N_AXIS  1 = the AXIS port is stalled by its external side
inst_idle_sigs  in  N_INST  1 = the instance is idle
inst_block_sigs  in  N_IBLK  1 = the instance is blocked on an internal channel
block  out  1  deadlock declared (registered)
block_pulse  out  1  single-cycle strobe on entry to BLOCKED
block_axis_snap  out  N_AXIS  axis_block_sigs value latched on entry to BLOCKED
stall_count  out  CNT_W  current count of consecutive stall cycles
block_events  out  8  number of BLOCKED entries, saturating at 255

Behaviour:
- Reset (kernel_monitor_reset=0, asynchronous): state=IDLE; block, block_pulse, block_axis_snap, stall_count, block_events and the internal pattern register all go to 0.
- Combinational stall condition `stall` = enable & ~(&inst_idle_sigs) & ((|axis_block_sigs) | (|inst_block_sigs)).
  - A fully idle kernel is never a deadlock.
- `pat` = {inst_block_sigs, axis_block_sigs}.
  - A change in `pat` between consecutive stall cycles counts as progress.
- States: IDLE, COUNT, BLOCKED. All outputs are registered and all transitions occur on the rising edge.
- IDLE:
  - If stall: latch pat, stall_count=1.
    - If THRESHOLD==1, go to BLOCKED.
    - Otherwise go to COUNT.
  - Otherwise stay in IDLE with stall_count=0.
- COUNT:
  - ~stall: go to IDLE, stall_count=0.
  - stall with pat changed: stay in COUNT, re-latch pat, stall_count=1 (restart).
  - stall with pat unchanged:
    - stall_count+1.
    - If the new value equals THRESHOLD, go to BLOCKED on the same edge.
- Entry into BLOCKED, on the same edge:
  - block=1, block_pulse=1, block_axis_snap=axis_block_sigs.
  - block_events incremented, holding at 255 (no wrap).
- BLOCKED:
  - block_pulse=0 after the entry cycle.
  - stall_count saturates at 2^CNT_W-1.
  - If stall is lost or pat changes:
    - STICKY=0: go to IDLE; block=0, stall_count=0.
    - STICKY=1: go to IDLE with the counter zeroed, but block stays 1 until clear.
- Latency: block rises on the THRESHOLD-th consecutive rising edge at which a stable stall is sampled.
  - block falls one edge after the stall resolves (STICKY=0).
- clear:
  - Zeroes block (sticky case), block_axis_snap and block_events.
  - Does not change state or stall_count unless a re-entry occurs.
  - clear together with a BLOCKED entry on the same edge: the entry wins. block=1, the snapshot is loaded and block_events=1.
- enable=0: forced to IDLE and stall_count=0 on the next edge. block, the snapshot and the event counter are kept, except that block drops when STICKY=0.
- Reset asserted mid-count or while blocked: everything returns to its reset value immediately, with no dependence on the clock.

Test Plan:
- THRESHOLD=4, STICKY=0; idle=2'b00, axis=2'b01 held for 6 cycles.
  - stall_count reads 1,2,3,4; block rises on the 4th edge.
  - block_pulse is 1 for one cycle; snap=2'b01; block_events=1.
- Same setup, then axis→00 → block=0 and stall_count=0 on the next edge.
- axis alternates 01,10 every 2 cycles for 20 cycles → stall_count never exceeds 2 and block stays 0 (progress detected).
- inst_idle=2'b11 with axis=2'b11 for 50 cycles → stall=0, block=0, stall_count=0.
- STICKY=1: deadlock, then the stall resolves → block remains 1.
  - clear for one cycle → block=0, snap=0, block_events=0.
  - Re-stall for 4 cycles → block=1, block_events=1.
- Reset pulse low mid-COUNT (count=3) at a non-edge time → outputs 0 immediately.
  - After release, a fresh 4-cycle stall → block rises on the 4th edge.
